rename_map_repair: RTL

Speculative rename map table (RMT) with its repair receiver: the consumer of the repair packet stream the architectural map table emits after a misprediction, load violation or exception. Holds one physical-register mapping per logical register, serves rename-stage lookups and updates with intra-group bypass, and overwrites entries from incoming repair packets. While a repair is in progress it stalls rename, tracks which entries have been restored, and reports completion or incomplete coverage.

---
 rtl/rename_map_repair_if.sv | 36 +++
 rtl/rename_map_repair.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rename_map_repair_if.sv
// Rename-stage and repair-packet signal bundle for the speculative map table.
// The master side drives rename requests and repair packets; the slave side is the map table.
interface rename_map_repair_if #(
  parameter int RENAME_WIDTH      = 2,
  parameter int N_REPAIR_PACKETS  = 4,
  parameter int SIZE_RMT_LOG      = 6,
  parameter int SIZE_PHYSICAL_LOG = 7
);
  logic                                                repairFlag_i;
  logic [N_REPAIR_PACKETS-1:0][SIZE_RMT_LOG-1:0]      repairAddr_i;
  logic [N_REPAIR_PACKETS-1:0][SIZE_PHYSICAL_LOG-1:0] repairData_i;
  logic [RENAME_WIDTH-1:0]                             renameValid_i;
  logic [RENAME_WIDTH-1:0]                             renameHasDst_i;
  logic [RENAME_WIDTH-1:0][SIZE_RMT_LOG-1:0]          src1Addr_i;
  logic [RENAME_WIDTH-1:0][SIZE_RMT_LOG-1:0]          src2Addr_i;
  logic [RENAME_WIDTH-1:0][SIZE_RMT_LOG-1:0]          dstAddr_i;
  logic [RENAME_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]     newPhy_i;
  logic [RENAME_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]     src1Phy_o;
  logic [RENAME_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]     src2Phy_o;
  logic [RENAME_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]     oldDstPhy_o;
  logic                                                stall_o;
  logic                                                repairDone_o;
  logic                                                repairError_o;

  modport master (
    output repairFlag_i, repairAddr_i, repairData_i,
    output renameValid_i, renameHasDst_i, src1Addr_i, src2Addr_i, dstAddr_i, newPhy_i,
    input  src1Phy_o, src2Phy_o, oldDstPhy_o, stall_o, repairDone_o, repairError_o
  );

  modport slave (
    input  repairFlag_i, repairAddr_i, repairData_i,
    input  renameValid_i, renameHasDst_i, src1Addr_i, src2Addr_i, dstAddr_i, newPhy_i,
    output src1Phy_o, src2Phy_o, oldDstPhy_o, stall_o, repairDone_o, repairError_o
  );
endinterface

// File: rtl/rename_map_repair.sv
// Speculative rename map table with repair-packet receiver.
// Serves combinational rename lookups with intra-group bypass, accepts rename
// writes when not stalled, and rebuilds itself from repair packets while
// tracking which entries have been restored in each repair episode.
module rename_map_repair #(
  parameter int RENAME_WIDTH      = 2,
  parameter int N_REPAIR_PACKETS  = 4,
  parameter int SIZE_RMT          = 34,
  parameter int SIZE_RMT_LOG      = 6,
  parameter int SIZE_PHYSICAL_LOG = 7
) (
  input  logic               clk,
  input  logic               reset,
  rename_map_repair_if.slave bus
);

  typedef logic [SIZE_PHYSICAL_LOG-1:0] phys_t;
  typedef enum logic [1:0] {S_IDLE, S_REPAIR, S_DRAIN} state_t;

  state_t              r_state;
  phys_t               r_map [SIZE_RMT];
  logic [SIZE_RMT-1:0] r_cov;
  logic                r_done;
  logic                r_error;

  phys_t               w_map_next [SIZE_RMT];
  logic [SIZE_RMT-1:0] w_cov_next;
  logic                w_stall;
  phys_t               w_src1 [RENAME_WIDTH];
  phys_t               w_src2 [RENAME_WIDTH];
  phys_t               w_old  [RENAME_WIDTH];

  assign w_stall           = (r_state != S_IDLE) || bus.repairFlag_i;
  assign bus.stall_o       = w_stall;
  assign bus.repairDone_o  = r_done;
  assign bus.repairError_o = r_error;

  // Next table contents and coverage: repair packets (higher index wins) or unstalled rename writes (higher lane wins).
  always_comb begin
    w_map_next = r_map;
    w_cov_next = r_cov;
    if (bus.repairFlag_i) begin
      // A flag cycle outside REPAIR starts a new episode, so coverage restarts before this cycle's bits.
      if (r_state != S_REPAIR) w_cov_next = '0;
      for (int unsigned p = 0; p < N_REPAIR_PACKETS; p++) begin
        if (int'(bus.repairAddr_i[p]) < SIZE_RMT) begin
          w_map_next[bus.repairAddr_i[p]] = bus.repairData_i[p];
          w_cov_next[bus.repairAddr_i[p]] = 1'b1;
        end
      end
    end
    if (!w_stall) begin
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
        if (bus.renameValid_i[k] && bus.renameHasDst_i[k]) begin
          w_map_next[bus.dstAddr_i[k]] = bus.newPhy_i[k];
        end
      end
    end
  end

  // Rename lookups: table read, then overridden by the youngest older lane writing the same logical register.
  always_comb begin
    for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
      w_src1[k] = r_map[bus.src1Addr_i[k]];
      w_src2[k] = r_map[bus.src2Addr_i[k]];
      w_old[k]  = r_map[bus.dstAddr_i[k]];
      for (int unsigned j = 0; j < k; j++) begin
        if (bus.renameValid_i[j] && bus.renameHasDst_i[j]) begin
          if (bus.dstAddr_i[j] == bus.src1Addr_i[k]) w_src1[k] = bus.newPhy_i[j];
          if (bus.dstAddr_i[j] == bus.src2Addr_i[k]) w_src2[k] = bus.newPhy_i[j];
          if (bus.dstAddr_i[j] == bus.dstAddr_i[k])  w_old[k]  = bus.newPhy_i[j];
        end
      end
    end
  end

  // Drive the packed lookup outputs from the per-lane results.
  always_comb begin
    for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
      bus.src1Phy_o[k]   = w_src1[k];
      bus.src2Phy_o[k]   = w_src2[k];
      bus.oldDstPhy_o[k] = w_old[k];
    end
  end

  // Map table storage; reset restores the identity mapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SIZE_RMT; i++) begin
        r_map[i] <= SIZE_PHYSICAL_LOG'(i);
      end
    end else begin
      r_map <= w_map_next;
    end
  end

  // Repair FSM, coverage bitmap and the registered completion pulses shown during DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cov   <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_cov   <= w_cov_next;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.repairFlag_i) r_state <= S_REPAIR;
        end
        S_REPAIR: begin
          // No packets arrive on the flag-low cycle, so r_cov already holds the episode's final coverage.
          if (!bus.repairFlag_i) begin
            r_state <= S_DRAIN;
            r_done  <= &r_cov;
            r_error <= ~&r_cov;
          end
        end
        S_DRAIN: begin
          r_state <= bus.repairFlag_i ? S_REPAIR : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
